// File: rtl/banco_reg_param.sv
// Parametrised register bank: one write port, N_RD registered read ports, one memory copy per
// read port. An init sequencer zeroes every entry after reset before the bank reports listo.
module banco_reg_param #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int N_RD      = 2,
   parameter int BYPASS    = 1,
   parameter int ZERO_REG0 = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     hab_w,
   input  logic [ADDR_W-1:0]        addr_w,
   input  logic [DATA_W-1:0]        data_w,
   input  logic [N_RD-1:0]          hab_r,
   input  logic [N_RD*ADDR_W-1:0]   addr_r,
   output logic [N_RD*DATA_W-1:0]   data_r,
   output logic                     listo,
   output logic                     o_dbg_estado
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} estado_t;

   estado_t           r_estado, w_estado_next;
   logic [ADDR_W-1:0] r_cnt, w_cnt_next;
   logic              r_listo, w_listo_next;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_estado <= INIT;
         r_cnt    <= '0;
         r_listo  <= 1'b0;
      end else begin
         r_estado <= w_estado_next;
         r_cnt    <= w_cnt_next;
         r_listo  <= w_listo_next;
      end
   end

   always_comb begin
      w_estado_next = r_estado;
      w_cnt_next    = r_cnt;
      w_listo_next  = r_listo;
      case (r_estado)
         INIT: begin
            // Last clearing write happens at DEPTH-1; cnt holds there instead of wrapping.
            if (r_cnt == ADDR_W'(DEPTH - 1)) begin
               w_estado_next = RUN;
               w_listo_next  = 1'b1;
            end else begin
               w_cnt_next = r_cnt + ADDR_W'(1);
            end
         end
         RUN: begin
            w_estado_next = RUN;
         end
         default: begin
            w_estado_next = INIT;
         end
      endcase
   end

   assign listo        = r_listo;
   assign o_dbg_estado = (r_estado == RUN);

   // Shared write port: the sequencer owns it during INIT, writeback owns it in RUN.
   logic              w_discard;
   logic              w_user_we;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;

   assign w_discard = (ZERO_REG0 != 0) && (addr_w == '0);
   assign w_user_we = hab_w && !w_discard;
   assign w_we      = rst && ((r_estado == INIT) || w_user_we);
   assign w_waddr   = (r_estado == INIT) ? r_cnt : addr_w;
   assign w_wdata   = (r_estado == INIT) ? '0 : data_w;

   for (genvar i = 0; i < N_RD; i++) begin : g_bank
      logic [DATA_W-1:0] r_mem [DEPTH];
      logic [DATA_W-1:0] r_data;
      logic [ADDR_W-1:0] w_raddr;
      logic              w_bypass;
      logic [DATA_W-1:0] w_rdata;

      assign w_raddr  = addr_r[i*ADDR_W +: ADDR_W];
      assign w_bypass = (BYPASS != 0) && w_user_we && (addr_w == w_raddr);

      always_comb begin
         w_rdata = r_mem[w_raddr];
         if ((ZERO_REG0 != 0) && (w_raddr == '0)) begin
            w_rdata = '0;
         end else if (w_bypass) begin
            w_rdata = data_w;
         end
      end

      always_ff @(posedge clk) begin
         if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            r_data <= '0;
         end else if ((r_estado == RUN) && hab_r[i]) begin
            r_data <= w_rdata;
         end
      end

      assign data_r[i*DATA_W +: DATA_W] = r_data;
   end

endmodule

// File: tb/tb_banco_reg_param.sv
// Bench for banco_reg_param: two instances (bypass+zero-reg, and neither) driven in parallel,
// checked every cycle against a behavioural model plus directed literal expectations.
module tb_banco_reg_param;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int DEPTH = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            hab_w;
   logic [AW-1:0]   addr_w;
   logic [DW-1:0]   data_w;
   logic [NR-1:0]   hab_r;
   logic [NR*AW-1:0] addr_r;
   logic [NR*DW-1:0] data_r_a, data_r_b;
   logic            listo_a, listo_b;
   logic            dbg_a, dbg_b;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

   banco_reg_param #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .BYPASS(1), .ZERO_REG0(1)) u_dut_a (
      .clk(clk), .rst(rst), .hab_w(hab_w), .addr_w(addr_w), .data_w(data_w),
      .hab_r(hab_r), .addr_r(addr_r), .data_r(data_r_a), .listo(listo_a), .o_dbg_estado(dbg_a));

   banco_reg_param #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .BYPASS(0), .ZERO_REG0(0)) u_dut_b (
      .clk(clk), .rst(rst), .hab_w(hab_w), .addr_w(addr_w), .data_w(data_w),
      .hab_r(hab_r), .addr_r(addr_r), .data_r(data_r_b), .listo(listo_b), .o_dbg_estado(dbg_b));

   // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) ----------------
   logic [DW-1:0] m_mem  [2][DEPTH];
   logic [DW-1:0] m_data [2][NR];
   bit            m_listo;
   int            m_cyc;

   always @(posedge clk) begin
      if (!rst) begin
         m_cyc   = 0;
         m_listo = 1'b0;
         for (int k = 0; k < 2; k++)
            for (int p = 0; p < NR; p++) m_data[k][p] = '0;
      end else if (!m_listo) begin
         m_cyc = m_cyc + 1;
         if (m_cyc == DEPTH) begin
            m_listo = 1'b1;
            for (int k = 0; k < 2; k++)
               for (int a = 0; a < DEPTH; a++) m_mem[k][a] = '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            bit zr, byp, wr_ok;
            zr    = (k == 0);
            byp   = (k == 0);
            wr_ok = hab_w && !(zr && addr_w == 0);
            for (int p = 0; p < NR; p++) begin
               int ra;
               ra = int'(addr_r[p*AW +: AW]);
               if (hab_r[p]) begin
                  if (zr && ra == 0)                          m_data[k][p] = '0;
                  else if (byp && wr_ok && int'(addr_w) == ra) m_data[k][p] = data_w;
                  else                                        m_data[k][p] = m_mem[k][ra];
               end
            end
            if (wr_ok) m_mem[k][addr_w] = data_w;
         end
      end
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_listo_a", DW'(listo_a), DW'(m_listo));
         check("model_listo_b", DW'(listo_b), DW'(m_listo));
         for (int p = 0; p < NR; p++) begin
            check("model_data_a", data_r_a[p*DW +: DW], m_data[0][p]);
            check("model_data_b", data_r_b[p*DW +: DW], m_data[1][p]);
         end
      end
   end

   // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
   task automatic op(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic [NR-1:0] re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
      hab_w  = we;
      addr_w = wa;
      data_w = wd;
      hab_r  = re;
      addr_r = {ra1, ra0};
      @(negedge clk);
      hab_w = 1'b0;
      hab_r = '0;
   endtask

   // Counts rising edges until listo; hab_w is dropped as soon as the bank becomes ready.
   task automatic wait_listo(output int n);
      n = 0;
      while (!listo_a && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      hab_w = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [DW-1:0] pa(input int p);
      return data_r_a[p*DW +: DW];
   endfunction

   function automatic logic [DW-1:0] pb(input int p);
      return data_r_b[p*DW +: DW];
   endfunction

   initial begin
      int n;
      rst = 1'b0; hab_w = 1'b0; addr_w = '0; data_w = '0; hab_r = '0; addr_r = '0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("reset_listo", DW'(listo_a), 32'h0);
      check("reset_data", pa(0), 32'h0);

      // T1: init length and cleared contents
      rst = 1'b1;
      wait_listo(n);
      check("t1_init_cycles", DW'(n), 32'd32);
      for (int a = 0; a < DEPTH; a++) begin
         op(1'b0, '0, '0, 2'b11, AW'(a), AW'(DEPTH - 1 - a));
         check("t1_clear_p0", pb(0), 32'h0);
         check("t1_clear_p1", pb(1), 32'h0);
      end

      // T2: write then read
      op(1'b1, 5'd7, 32'h11, 2'b00, '0, '0);
      op(1'b1, 5'd5, 32'hDEADBEEF, 2'b00, '0, '0);
      op(1'b0, '0, '0, 2'b11, 5'd5, 5'd0);
      check("t2_a_p0", pa(0), 32'hDEADBEEF);
      check("t2_a_p1", pa(1), 32'h0);
      check("t2_b_p0", pb(0), 32'hDEADBEEF);

      // T3: zero register
      op(1'b1, 5'd0, 32'h12345678, 2'b00, '0, '0);
      op(1'b0, '0, '0, 2'b11, 5'd0, 5'd0);
      check("t3_a_p0", pa(0), 32'h0);
      check("t3_a_p1", pa(1), 32'h0);
      check("t3_b_p0", pb(0), 32'h12345678);
      check("t3_b_p1", pb(1), 32'h12345678);

      // T4: bypass vs old data
      op(1'b1, 5'd7, 32'h22, 2'b11, 5'd7, 5'd7);
      check("t4_a_p0", pa(0), 32'h22);
      check("t4_a_p1", pa(1), 32'h22);
      check("t4_b_p0", pb(0), 32'h11);
      check("t4_b_p1", pb(1), 32'h11);
      op(1'b0, '0, '0, 2'b11, 5'd7, 5'd7);
      check("t4_b_next", pb(1), 32'h22);

      // T5: hold with hab_r low
      op(1'b0, '0, '0, 2'b01, 5'd5, 5'd0);
      check("t5_read", pa(0), 32'hDEADBEEF);
      op(1'b1, 5'd5, 32'hCAFEF00D, 2'b00, 5'd3, 5'd4);
      check("t5_hold_a", pa(0), 32'hDEADBEEF);
      op(1'b0, '0, '0, 2'b10, 5'd9, 5'd5);
      check("t5_hold_p0", pa(0), 32'hDEADBEEF);
      check("t5_new_p1", pa(1), 32'hCAFEF00D);

      // T6: reset in RUN, then reset at cnt=10 in INIT with writes attempted throughout
      rst = 1'b0;
      @(negedge clk);
      check("t6_run_rst_listo", DW'(listo_a), 32'h0);
      check("t6_run_rst_data", pa(1), 32'h0);
      rst = 1'b1;
      hab_w = 1'b1; addr_w = 5'd9; data_w = 32'h0000FFFF;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t6_init_rst_listo", DW'(listo_b), 32'h0);
      rst = 1'b1;
      wait_listo(n);
      check("t6_reinit_cycles", DW'(n), 32'd32);
      op(1'b0, '0, '0, 2'b11, 5'd5, 5'd9);
      check("t6_x5_a", pa(0), 32'h0);
      check("t6_x9_a", pa(1), 32'h0);
      check("t6_x5_b", pb(0), 32'h0);
      check("t6_x9_b", pb(1), 32'h0);

      // Post-reset write/read sanity with both ports on one address
      op(1'b1, 5'd31, 32'hA5A5A5A5, 2'b00, '0, '0);
      op(1'b0, '0, '0, 2'b11, 5'd31, 5'd31);
      check("t6_after_p0", pa(0), 32'hA5A5A5A5);
      check("t6_after_p1", pb(1), 32'hA5A5A5A5);

      repeat (2) @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
